full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder.sv | 46 ++++
 tb/tb_full_adder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder with registered result and saturating carry counter
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic [15:0]      carry_cnt
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  assign cout = c[WIDTH];
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      carry_cnt <= 16'd0;
    end else begin
      sum_q     <= sum;
      cout_q    <= cout;
      carry_cnt <= (cout && carry_cnt != 16'hFFFF) ? carry_cnt + 16'd1 : carry_cnt;
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed self-checking bench for full_adder at WIDTH 1 and 8
module tb_full_adder;
  logic        clk = 1'b0;
  logic        rst1, rst8;
  logic        a1, b1, cin1, cin8;
  logic [7:0]  a8, b8;
  logic        sum1, cout1, ovf1, sum_q1, cout_q1;
  logic [7:0]  sum8, sum_q8;
  logic        cout8, ovf8, cout_q8;
  logic [15:0] cnt1, cnt8;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_s, exp_c;
  logic [2:0]  v;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .ovf(ovf1),
    .sum_q(sum_q1), .cout_q(cout_q1), .carry_cnt(cnt1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .ovf(ovf8),
    .sum_q(sum_q8), .cout_q(cout_q8), .carry_cnt(cnt8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci;
    #1;
    check("w8_sum", 32'(sum8), 32'(es));
    check("w8_cout", 32'(cout8), 32'(ec));
    check("w8_ovf", 32'(ovf8), 32'(eo));
  endtask

  initial begin
    rst1 = 1'b1; rst8 = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_q1", 32'(sum_q1), 32'd0);
    check("rst_cout_q1", 32'(cout_q1), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_sum_q8", 32'(sum_q8), 32'd0);
    check("rst_cnt8", 32'(cnt8), 32'd0);

    exp_s = 8'b10010110;
    exp_c = 8'b11101000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      check("w1_sum", 32'(sum1), 32'(exp_s[i]));
      check("w1_cout", 32'(cout1), 32'(exp_c[i]));
      check("w1_ovf", 32'(ovf1), 32'(exp_c[i] ^ v[0]));
      check("w1_sum_q_in_rst", 32'(sum_q1), 32'd0);
    end

    comb8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    comb8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    comb8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    comb8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    comb8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    comb8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    comb8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    @(negedge clk);
    rst8 = 1'b0;
    @(posedge clk);
    #1;
    check("w8_sum_q", 32'(sum_q8), 32'h47);
    check("w8_cout_q", 32'(cout_q8), 32'd0);
    check("w8_cnt_nocarry", 32'(cnt8), 32'd0);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk);
    #1;
    check("w8_sum_q_ff", 32'(sum_q8), 32'hFF);
    check("w8_cout_q_ff", 32'(cout_q8), 32'd1);
    check("w8_cnt_carry", 32'(cnt8), 32'd1);

    @(negedge clk);
    rst1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk);
    #1;
    check("reg_sum_q", 32'(sum_q1), 32'd0);
    check("reg_cout_q", 32'(cout_q1), 32'd1);
    check("reg_cnt", 32'(cnt1), 32'd1);
    @(negedge clk);
    b1 = 1'b0;
    @(posedge clk);
    #1;
    check("reg_sum_q2", 32'(sum_q1), 32'd1);
    check("reg_cout_q2", 32'(cout_q1), 32'd0);
    check("reg_cnt_hold", 32'(cnt1), 32'd1);

    @(negedge clk);
    b1 = 1'b1; rst1 = 1'b1;
    @(posedge clk);
    #1;
    check("rst_pri_sum_q", 32'(sum_q1), 32'd0);
    check("rst_pri_cout_q", 32'(cout_q1), 32'd0);
    check("rst_pri_cnt", 32'(cnt1), 32'd0);
    check("rst_comb_sum", 32'(sum1), 32'd0);
    check("rst_comb_cout", 32'(cout1), 32'd1);

    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    check("resume_cout_q", 32'(cout_q1), 32'd1);
    check("resume_cnt", 32'(cnt1), 32'd1);

    repeat (65533) @(posedge clk);
    #1;
    check("sat_fffe", 32'(cnt1), 32'hFFFE);
    @(posedge clk);
    #1;
    check("sat_ffff", 32'(cnt1), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", 32'(cnt1), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
